// File: rtl/cordic_seq.sv
// Sequential radix-2 CORDIC engine: one micro-rotation per clock, rotation or vectoring mode,
// with quadrant pre-rotation, saturated outputs and an IDLE/RUN/DONE valid-ready handshake.
module cordic_seq #(
    parameter int WIDTH = 32,
    parameter int ITER  = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             mode,
    input  logic [WIDTH-1:0] x_in,
    input  logic [WIDTH-1:0] y_in,
    input  logic [WIDTH-1:0] z_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] x_out,
    output logic [WIDTH-1:0] y_out,
    output logic [WIDTH-1:0] z_out,
    output logic             err
);

    localparam int EW = WIDTH + 2;
    localparam int GB = 12;
    localparam int FB = WIDTH - 2 + GB;
    localparam int GW = WIDTH + GB + 8;
    localparam int CW = $clog2(ITER);

    // atan(1/q) by Taylor series in fixed point with GB guard bits below the output LSB
    function automatic logic [GW-1:0] atanRecip(input logic [GW-1:0] q);
        logic [GW-1:0] term, acc;
        term = (GW'(1) << FB) / q;
        acc  = '0;
        for (int k = 0; k < 2*GW; k++) begin
            if (k % 2 == 0) acc = acc + term / GW'(2*k+1);
            else            acc = acc - term / GW'(2*k+1);
            term = term / q / q;
        end
        return acc;
    endfunction

    function automatic logic [GW-1:0] quarterPi();
        return (atanRecip(GW'(5)) << 2) - atanRecip(GW'(239));
    endfunction

    function automatic logic [WIDTH-1:0] roundQ(input logic [GW-1:0] v);
        return WIDTH'((v + (GW'(1) << (GB-1))) >> GB);
    endfunction

    function automatic logic [WIDTH-1:0] atanEntry(input int i);
        return roundQ((i == 0) ? quarterPi() : atanRecip(GW'(1) << i));
    endfunction

    function automatic logic [WIDTH-1:0] sat(input logic signed [EW-1:0] v);
        if (v[EW-1:WIDTH-1] == '0 || v[EW-1:WIDTH-1] == '1) return v[WIDTH-1:0];
        else if (v[EW-1])                                   return {1'b1, {(WIDTH-1){1'b0}}};
        else                                                return {1'b0, {(WIDTH-1){1'b1}}};
    endfunction

    localparam logic signed [WIDTH-1:0] HALF_PI = roundQ(quarterPi() << 1);

    logic [ITER-1:0][WIDTH-1:0] atanTab;
    for (genvar g = 0; g < ITER; g++) begin : gAtan
        localparam logic [WIDTH-1:0] ATAN_G = atanEntry(g);
        assign atanTab[g] = ATAN_G;
    end

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t state, stateNext;

    logic [CW-1:0]           iter;
    logic                    modeReg;
    logic signed [EW-1:0]    xr, yr;
    logic signed [WIDTH-1:0] zr;

    logic                    accept, vecErr, lastIter;
    logic                    dPos;
    logic signed [EW-1:0]    xSh, ySh, xNew, yNew;
    logic signed [WIDTH-1:0] zNew, atanI;
    logic signed [EW-1:0]    xIn, yIn, xLoad, yLoad;
    logic signed [WIDTH-1:0] zIn, zLoad;

    assign accept   = in_valid && in_ready;
    assign vecErr   = mode && x_in[WIDTH-1];
    assign lastIter = (iter == CW'(ITER-1));

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= stateNext;
    end

    // Next-state logic
    always_comb begin
        stateNext = state;
        case (state)
            IDLE:    if (accept) stateNext = vecErr ? DONE : RUN;
            RUN:     if (lastIter) stateNext = DONE;
            DONE:    if (out_ready) stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    // Handshake outputs
    always_comb begin
        in_ready  = (state == IDLE);
        out_valid = (state == DONE);
    end

    // Pre-rotation folds |z| > pi/2 into the convergence range of the iteration
    always_comb begin
        xIn   = {{2{x_in[WIDTH-1]}}, x_in};
        yIn   = {{2{y_in[WIDTH-1]}}, y_in};
        zIn   = $signed(z_in);
        xLoad = xIn;
        yLoad = yIn;
        zLoad = zIn;
        if (!mode && zIn > HALF_PI) begin
            xLoad = -yIn;
            yLoad = xIn;
            zLoad = zIn - HALF_PI;
        end else if (!mode && zIn < -HALF_PI) begin
            xLoad = yIn;
            yLoad = -xIn;
            zLoad = zIn + HALF_PI;
        end
    end

    always_comb begin
        dPos  = modeReg ? yr[EW-1] : ~zr[WIDTH-1];
        xSh   = xr >>> iter;
        ySh   = yr >>> iter;
        atanI = $signed(atanTab[iter]);
        xNew  = xr + ySh;
        yNew  = yr - xSh;
        zNew  = zr + atanI;
        if (dPos) begin
            xNew = xr - ySh;
            yNew = yr + xSh;
            zNew = zr - atanI;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            iter    <= '0;
            modeReg <= 1'b0;
            xr      <= '0;
            yr      <= '0;
            zr      <= '0;
            x_out   <= '0;
            y_out   <= '0;
            z_out   <= '0;
            err     <= 1'b0;
        end else if (accept) begin
            iter    <= '0;
            modeReg <= mode;
            err     <= vecErr;
            xr      <= xLoad;
            yr      <= yLoad;
            zr      <= zLoad;
            if (vecErr) begin
                x_out <= '0;
                y_out <= '0;
                z_out <= '0;
            end
        end else if (state == RUN) begin
            iter <= iter + 1'b1;
            xr   <= xNew;
            yr   <= yNew;
            zr   <= zNew;
            if (lastIter) begin
                x_out <= sat(xNew);
                y_out <= sat(yNew);
                z_out <= zNew;
            end
        end
    end

endmodule
